bsg_hash_bank_seq: RTL and testbench



---
 rtl/bsg_hash_bank_seq_pkg.sv | 22 ++
 rtl/bsg_hash_bank_seq_divider.sv | 62 ++++++
 rtl/bsg_hash_bank_seq.sv | 130 +++++++++++++
 tb/tb_bsg_hash_bank_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_hash_bank_seq_pkg.sv
// Width helpers shared by the bank-split stage and its divider.
package bsg_hash_bank_seq_pkg;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned safe_clog2(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned floor_log2(int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((n >> i) != 0) r = i;
    end
    return r;
  endfunction

  function automatic bit is_pow2(int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/bsg_hash_bank_seq_divider.sv
// Restoring divider by the constant banks_p, one quotient bit per cycle, MSB first.
module bsg_hash_bank_seq_divider
  import bsg_hash_bank_seq_pkg::*;
#(
  parameter int unsigned banks_p = 3,
  parameter int unsigned width_p = 32,
  localparam int unsigned bank_width_lp = safe_clog2(banks_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [width_p-1:0]       addr_i,
  output logic                     done_o,
  output logic [bank_width_lp-1:0] rem_o,
  output logic [width_p-1:0]       quot_o
);

  localparam int unsigned rem_width_lp = bank_width_lp + 1;
  localparam int unsigned cnt_width_lp = $clog2(width_p + 1);

  logic                     run_q;
  logic [cnt_width_lp-1:0]  cnt_q;
  logic [width_p-1:0]       addr_q, quot_q, quot_d;
  logic [bank_width_lp-1:0] rem_q, rem_d;
  logic [rem_width_lp-1:0]  rem_next;
  logic                     take_bit, last;

  assign rem_next = {rem_q, addr_q[width_p-1]};
  assign take_bit = rem_next >= rem_width_lp'(banks_p);
  // Remainder stays below banks_p, so the dropped top bit is always zero.
  assign rem_d    = bank_width_lp'(take_bit ? rem_next - rem_width_lp'(banks_p) : rem_next);
  assign quot_d   = {quot_q[width_p-2:0], take_bit};
  assign last     = (cnt_q == cnt_width_lp'(width_p - 1));

  // Results are presented during the final iteration so the caller can register them directly.
  assign done_o = run_q & last;
  assign rem_o  = rem_d;
  assign quot_o = quot_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      addr_q <= '0;
      rem_q  <= '0;
      quot_q <= '0;
    end else if (start_i) begin
      run_q  <= 1'b1;
      cnt_q  <= '0;
      addr_q <= addr_i;
      rem_q  <= '0;
      quot_q <= '0;
    end else if (run_q) begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      addr_q <= {addr_q[width_p-2:0], 1'b0};
      cnt_q  <= cnt_q + cnt_width_lp'(1);
      if (last) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bsg_hash_bank_seq.sv
// Splits a flat address into (bank, index) with addr == index*banks_p + bank.
module bsg_hash_bank_seq
  import bsg_hash_bank_seq_pkg::*;
#(
  parameter int unsigned banks_p = 1,
  parameter int unsigned width_p = 32,
  localparam int unsigned bank_width_lp  = safe_clog2(banks_p),
  localparam int unsigned index_width_lp = width_p - floor_log2(banks_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [width_p-1:0]        addr_i,
  output logic                      ready_o,
  output logic                      v_o,
  output logic [bank_width_lp-1:0]  bank_o,
  output logic [index_width_lp-1:0] index_o,
  input  logic                      yumi_i
);

  localparam bit          pow2_lp  = is_pow2(banks_p);
  localparam int unsigned shift_lp = floor_log2(banks_p);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [bank_width_lp-1:0]  bank_q, bank_d, direct_bank, div_bank;
  logic [index_width_lp-1:0] index_q, index_d, direct_index, div_index;
  logic                      load, div_done;

  if (pow2_lp) begin : g_pow2
    if (banks_p == 1) begin : g_one
      assign direct_bank  = '0;
      assign direct_index = addr_i;
    end else begin : g_many
      assign direct_bank  = addr_i[bank_width_lp-1:0];
      assign direct_index = addr_i[width_p-1:shift_lp];
    end
    assign div_done  = 1'b0;
    assign div_bank  = '0;
    assign div_index = '0;
  end else begin : g_div
    logic [width_p-1:0] quot;

    bsg_hash_bank_seq_divider #(
      .banks_p(banks_p),
      .width_p(width_p)
    ) u_divider (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .start_i((state_q == StIdle) && v_i),
      .addr_i (addr_i),
      .done_o (div_done),
      .rem_o  (div_bank),
      .quot_o (quot)
    );

    assign div_index    = quot[index_width_lp-1:0];
    assign direct_bank  = '0;
    assign direct_index = '0;

    always_ff @(posedge clk_i) begin
      if (!reset_i && div_done) begin
        assert (quot[width_p-1:index_width_lp] == '0)
          else $error("quotient overflows index width: %h", quot);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    bank_d  = bank_q;
    index_d = index_q;
    case (state_q)
      StIdle: begin
        if (v_i) begin
          if (pow2_lp) begin
            load    = 1'b1;
            bank_d  = direct_bank;
            index_d = direct_index;
            state_d = StDone;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (div_done) begin
          load    = 1'b1;
          bank_d  = div_bank;
          index_d = div_index;
          state_d = StDone;
        end
      end
      StDone: begin
        if (yumi_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      bank_q  <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        bank_q  <= bank_d;
        index_q <= index_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && yumi_i) begin
      assert (state_q == StDone) else $error("yumi_i asserted while v_o is low");
    end
  end

  assign ready_o = (state_q == StIdle);
  assign v_o     = (state_q == StDone);
  assign bank_o  = bank_q;
  assign index_o = index_q;

endmodule

// File: tb/tb_bsg_hash_bank_seq.sv
// Directed and randomised checks of bsg_hash_bank_seq for banks_p of 1, 3, 4 and 5.
module tb_bsg_hash_bank_seq;

  function automatic int unsigned banks_tab(int g);
    case (g)
      0: return 1;
      1: return 3;
      2: return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int unsigned bw_tab(int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int unsigned iw_tab(int g);
    case (g)
      0: return 32;
      1: return 31;
      default: return 30;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  v_i, yumi_i, ready_o, v_o;
  logic [31:0] addr_i  [4];
  logic [31:0] bank_o  [4];
  logic [31:0] index_o [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned B  = banks_tab(g);
    localparam int unsigned BW = bw_tab(g);
    localparam int unsigned IW = iw_tab(g);
    logic [BW-1:0] bank;
    logic [IW-1:0] index;

    bsg_hash_bank_seq #(
      .banks_p(B),
      .width_p(32)
    ) u_dut (
      .clk_i  (clk),
      .reset_i(reset),
      .v_i    (v_i[g]),
      .addr_i (addr_i[g]),
      .ready_o(ready_o[g]),
      .v_o    (v_o[g]),
      .bank_o (bank),
      .index_o(index),
      .yumi_i (yumi_i[g])
    );

    assign bank_o[g]  = 32'(bank);
    assign index_o[g] = 32'(index);
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge.
  task automatic send(int g, logic [31:0] a);
    int k;
    k = 0;
    while (!ready_o[g] && k < 200) begin
      tick();
      k++;
    end
    check("send_ready", 64'(ready_o[g]), 1);
    v_i[g]    = 1'b1;
    addr_i[g] = a;
    tick();
    v_i[g] = 1'b0;
  endtask

  task automatic wait_v(int g, output int lat);
    lat = 1;
    while (!v_o[g] && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic take(int g);
    if (v_o[g]) begin
      yumi_i[g] = 1'b1;
      tick();
      yumi_i[g] = 1'b0;
    end
    check("take_ready", 64'(ready_o[g]), 1);
    check("take_v", 64'(v_o[g]), 0);
  endtask

  initial begin
    int          lat;
    logic [31:0] a, hb, hi;
    int unsigned b;

    reset  = 1'b1;
    v_i    = '0;
    yumi_i = '0;
    for (int g = 0; g < 4; g++) addr_i[g] = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    for (int g = 0; g < 4; g++) begin
      check("rst_v", 64'(v_o[g]), 0);
      check("rst_ready", 64'(ready_o[g]), 1);
      check("rst_bank", 64'(bank_o[g]), 0);
      check("rst_index", 64'(index_o[g]), 0);
    end

    // banks_p = 1
    send(0, 32'hDEADBEEF);
    wait_v(0, lat);
    check("b1_lat", 64'(lat), 1);
    check("b1_bank", 64'(bank_o[0]), 0);
    check("b1_index", 64'(index_o[0]), 64'h0DEADBEEF);
    check("b1_ready", 64'(ready_o[0]), 0);
    take(0);

    // banks_p = 4
    send(2, 32'h12345677);
    wait_v(2, lat);
    check("b4_lat", 64'(lat), 1);
    check("b4_bank", 64'(bank_o[2]), 3);
    check("b4_index", 64'(index_o[2]), 64'h048D159D);
    take(2);

    // banks_p = 3
    send(1, 32'd100);
    wait_v(1, lat);
    check("b3_lat", 64'(lat), 33);
    check("b3_bank", 64'(bank_o[1]), 1);
    check("b3_index", 64'(index_o[1]), 33);
    take(1);
    send(1, 32'hFFFFFFFF);
    wait_v(1, lat);
    check("b3max_bank", 64'(bank_o[1]), 0);
    check("b3max_index", 64'(index_o[1]), 64'h55555555);
    take(1);

    // banks_p = 5
    send(3, 32'd23);
    wait_v(3, lat);
    check("b5_lat", 64'(lat), 33);
    check("b5_bank", 64'(bank_o[3]), 3);
    check("b5_index", 64'(index_o[3]), 4);
    take(3);

    // Backpressure: result must hold and new requests must be ignored.
    send(1, 32'd50);
    wait_v(1, lat);
    for (int i = 0; i < 10; i++) begin
      v_i[1]    = i[0];
      addr_i[1] = 32'(i * 7 + 1);
      tick();
      check("bp_v", 64'(v_o[1]), 1);
      check("bp_ready", 64'(ready_o[1]), 0);
      check("bp_bank", 64'(bank_o[1]), 2);
      check("bp_index", 64'(index_o[1]), 16);
    end
    v_i[1] = 1'b0;
    take(1);

    // Reset in the middle of a division aborts it.
    send(1, 32'd1000);
    repeat (15) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_v", 64'(v_o[1]), 0);
    check("abort_ready", 64'(ready_o[1]), 1);
    repeat (40) tick();
    check("abort_quiet", 64'(v_o[1]), 0);
    send(1, 32'd7);
    wait_v(1, lat);
    check("fresh_lat", 64'(lat), 33);
    check("fresh_bank", 64'(bank_o[1]), 1);
    check("fresh_index", 64'(index_o[1]), 2);
    take(1);

    // Reset wins over a simultaneous request.
    reset     = 1'b1;
    v_i[2]    = 1'b1;
    addr_i[2] = 32'd5;
    tick();
    reset  = 1'b0;
    v_i[2] = 1'b0;
    tick();
    check("rstreq_v", 64'(v_o[2]), 0);
    check("rstreq_ready", 64'(ready_o[2]), 1);

    // Round trip with random addresses and random consumer delay.
    for (int g = 0; g < 4; g++) begin
      b = banks_tab(g);
      for (int n = 0; n < 250; n++) begin
        a = $urandom();
        send(g, a);
        wait_v(g, lat);
        repeat ($urandom_range(0, 3)) begin
          hb = bank_o[g];
          hi = index_o[g];
          tick();
          check("rt_hold", {bank_o[g], index_o[g]}, {hb, hi});
        end
        check("rt_v", 64'(v_o[g]), 1);
        check("rt_sum", 64'(index_o[g]) * 64'(b) + 64'(bank_o[g]), 64'(a));
        check("rt_mod", 64'(bank_o[g]), 64'(a % b));
        check("rt_lt", 64'(bank_o[g] < b), 1);
        take(g);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
